// File: rtl/shift_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB first, stop bit, one bit per bit_en strobe.
// A single holding register with valid/ready handshake; a low stop bit locks out until the line returns high.
module shift_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             sin,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A consumed word clears here; a load later in this block overrides it.
      if (valid && ready)
        valid <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!sin) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            shreg <= {shreg[WIDTH-2:0], sin};
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_BIT)
              state <= STOP;
          end
          STOP: begin
            busy <= 1'b0;
            if (sin) begin
              state <= IDLE;
              if (!valid || ready) begin
                dout  <= shreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              // Low stop bit: wait for the line to idle so it is never taken as a start bit.
              state     <= WAIT_HIGH;
              frame_err <= 1'b1;
            end
          end
          WAIT_HIGH: begin
            if (sin)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/shift_rx.md
SHIFT_RX -- requirements
Module: shift_rx

Interface
REQ-001 Parameter WIDTH, default 8, the number of data bits per frame; legal range 2..16.
REQ-002 Port clk, input, 1, rising-edge system clock.
REQ-003 Port reset, input, 1, asynchronous active-low reset.
REQ-004 Port bit_en, input, 1, one-clk strobe marking a serial bit-time; sin is sampled only on clk edges where bit_en=1.
REQ-005 Port sin, input, 1, serial line; idles high.
REQ-006 Port dout, output, WIDTH, received word (holding register).
REQ-007 Port valid, output, 1, dout holds an unconsumed word.
REQ-008 Port ready, input, 1, consumer accepts dout when valid=1 and ready=1 on the same clk edge.
REQ-009 Port busy, output, 1, high while a frame is in progress (states DATA and STOP).
REQ-010 Port frame_err, output, 1, one-clk pulse when a stop bit is sampled low.
REQ-011 Port overrun, output, 1, one-clk pulse when a good frame is dropped because the holding register is full.

Function
REQ-012 Frame format SHALL be: start bit 0, then WIDTH data bits MSB first, then stop bit 1, with one bit per bit_en strobe.
REQ-013 Assembly SHALL be by a left shift with the new bit entering the LSB, so the first data bit ends at dout[WIDTH-1].
REQ-014 The FSM SHALL have the states IDLE, DATA, STOP and WAIT_HIGH; all transitions occur only on edges with bit_en=1.
REQ-015 IDLE: sampled sin=0 -> DATA with bit counter=0; sampled sin=1 -> stay in IDLE.
REQ-016 DATA: each bit_en shifts sin into the shift register and increments the counter; on the sample where counter=WIDTH-1 -> STOP.
REQ-017 STOP, sin=1, with valid=0 or ready=1 in the same cycle: the shift register is loaded into dout, valid=1 on the next cycle, and the FSM goes to IDLE.
REQ-018 STOP, sin=1, with valid=1 and ready=0: the frame is dropped, overrun pulses for 1 clk, dout is unchanged and the FSM goes to IDLE.
REQ-019 STOP, sin=0: the frame is dropped, frame_err pulses for 1 clk, and the FSM goes to WAIT_HIGH.
REQ-020 WAIT_HIGH: sampled sin=1 -> IDLE; sampled sin=0 -> stay in WAIT_HIGH, with no further frame_err pulses.
REQ-021 A low stop bit SHALL never be treated as a start bit.
REQ-022 valid SHALL clear on the edge after valid&ready unless a new word loads on the same edge; a load wins and valid stays 1.
REQ-023 dout SHALL change only on a load, and SHALL be stable while valid=1 and ready=0.
REQ-024 Latency: valid SHALL rise exactly 1 clk after the stop-bit bit_en edge.
REQ-025 bit_en=0 cycles SHALL freeze the FSM, counter and shift register, with no timeout.
REQ-026 ready SHALL be ignored while valid=0.
REQ-027 busy SHALL be a registered decode of the state.
REQ-028 frame_err and overrun SHALL be registered, and SHALL never be high in the same cycle.

Reset
REQ-029 On reset=0 the block SHALL immediately, without waiting for clk, set state=IDLE, counter=0, shift register=0, dout=0, valid=0, busy=0, frame_err=0 and overrun=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no frame_err or overrun pulse.
REQ-031 After reset release the block SHALL wait in IDLE for a start bit.
REQ-032 The first clk edge after release SHALL be a normal functional edge.

Verification
REQ-033 WIDTH=8, bit_en every 4th clk, ready=1, frame 0,1,0,1,1,0,1,0,0,1 -> dout=8'hB4, valid for 1 clk, 1 clk after the stop edge; frame_err=0 and overrun=0.
REQ-034 Two back-to-back frames 8'hA5 then 8'h3C with ready=0 throughout -> dout=8'hA5 held, valid=1, one overrun pulse at the second stop edge.
REQ-035 Stop bit sampled 0 on frame 8'hFF -> frame_err pulses once and valid stays 0; sin held low 3 more bit times -> no new frame; sin=1, then frame 8'h01 -> dout=8'h01.
REQ-036 reset pulsed low after the 4th data bit, then a full frame 8'h81 -> no pulses and dout=8'h81; dout=0 and valid=0 during reset.
REQ-037 valid=1 with ready asserted on the exact edge of the next good stop bit -> new word loads, valid stays 1, no overrun pulse.
REQ-038 bit_en held low for 50 clk mid-frame, then resumed -> the frame completes correctly with no timeout.
